// File: rtl/dma_pkg.sv
// Shared types for the multi-channel DMA controller: FSM encoding, channel
// context record and memory-port constants.
package dma_pkg;
  localparam int CTX_AW = 16;

  typedef enum logic [3:0] {
    IDLE, ARB, MEM_RD, DEV_WR, DEV_RD, MEM_WR, YIELD, DONE, ERROR
  } dma_state_e;

  typedef struct packed {
    logic [CTX_AW-1:0] cur_addr;
    logic [CTX_AW-1:0] remaining;
    logic              busy;
    logic              dir;
  } ctx_t;

  localparam logic       DIR_RD  = 1'b1;
  localparam logic       DIR_WR  = 1'b0;
  localparam logic [1:0] WE_WORD = 2'b11;
endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter: searches from the channel after the last grant.
// Grant is combinational; the pointer only moves when advance is asserted.
module dma_rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [NCH-1:0] grant
);
  localparam int PW = $clog2(NCH);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_k;
  logic          w_found;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_k     = '0;
    for (int i = 0; i < NCH; i++) begin
      w_k = PW'((int'(r_ptr) + i) % NCH);
      if (!w_found && req[w_k]) begin
        w_found = 1'b1;
        w_idx   = w_k;
      end
    end
    grant = w_found ? ({{(NCH-1){1'b0}}, 1'b1} << w_idx) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ptr <= '0;
    else if (advance && w_found)
      r_ptr <= (w_idx == PW'(NCH - 1)) ? '0 : w_idx + PW'(1);
  end
endmodule

// File: rtl/dma_mc_controller.sv
// Multi-channel DMA engine: per-channel contexts time-share one memory port
// in bursts, moving one word at a time through a single staging register.
module dma_mc_controller
  import dma_pkg::*;
#(
  parameter int             ADDR_W      = CTX_AW,
  parameter int             DATA_W      = 16,
  parameter int             NCH         = 4,
  parameter int             BURST_LEN   = 8,
  parameter logic [NCH-1:0] HIPRIO_MASK = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          rqst,
  input  logic [NCH-1:0]          rd_wr,
  input  logic [NCH*(ADDR_W+1)-1:0] start_addr,
  input  logic [NCH*ADDR_W-1:0]   num_words,
  input  logic [NCH-1:0]          dev_ack,
  input  logic [NCH*DATA_W-1:0]   dev_in,
  output logic [DATA_W-1:0]       dev_out,
  output logic [NCH-1:0]          dma_ack,
  output logic [NCH-1:0]          end_flag,
  output logic [NCH-1:0]          err_flag,
  output logic [NCH-1:0]          busy,
  input  logic [DATA_W-1:0]       dma_in,
  input  logic                    dma_ready,
  input  logic                    dma_resp,
  output logic [ADDR_W-1:0]       dma_addr,
  output logic [DATA_W-1:0]       dma_out,
  output logic                    dma_en,
  output logic [1:0]              dma_we,
  output logic                    dma_priority
);
  localparam int CW = $clog2(NCH);
  localparam int BW = $clog2(BURST_LEN + 1);

  dma_state_e          r_state, w_next, w_after, w_word_nx;
  ctx_t [NCH-1:0]      r_ctx;
  logic [CW-1:0]       r_ch, w_gidx;
  logic [ADDR_W-1:0]   r_addr, r_rem;
  logic [BW-1:0]       r_burst;
  logic [DATA_W-1:0]   r_stage;
  logic [NCH-1:0]      r_zend, w_busy, w_grant, w_ch_oh, w_unused_lsb;
  logic [ADDR_W-1:0]   w_sa [NCH];
  logic [ADDR_W-1:0]   w_nw [NCH];
  logic [DATA_W-1:0]   w_din [NCH];
  logic                w_dir, w_step, w_adv;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign w_sa[c]         = start_addr[c*(ADDR_W+1)+1 +: ADDR_W];
    assign w_unused_lsb[c] = start_addr[c*(ADDR_W+1)];
    assign w_nw[c]         = num_words[c*ADDR_W +: ADDR_W];
    assign w_din[c]        = dev_in[c*DATA_W +: DATA_W];
    assign w_busy[c]       = r_ctx[c].busy;
  end

  assign busy  = w_busy;
  assign w_adv = (r_state == IDLE);

  dma_rr_arbiter #(.NCH(NCH)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (w_busy),
    .advance (w_adv),
    .grant   (w_grant)
  );

  always_comb begin
    w_gidx = '0;
    for (int c = 0; c < NCH; c++)
      if (w_grant[c]) w_gidx = CW'(c);
  end

  assign w_ch_oh   = {{(NCH-1){1'b0}}, 1'b1} << r_ch;
  assign w_dir     = r_ctx[r_ch].dir;
  assign w_word_nx = (w_dir == DIR_RD) ? MEM_RD : DEV_RD;
  assign w_step    = (r_state == DEV_WR && dev_ack[r_ch]) ||
                     (r_state == MEM_WR && dma_ready && !dma_resp);

  // Completion beats wrap: a final word at the top address is not an error.
  always_comb begin
    if (r_rem == ADDR_W'(1))                    w_after = DONE;
    else if (&r_addr)                           w_after = ERROR;
    else if (r_burst + BW'(1) == BW'(BURST_LEN)) w_after = YIELD;
    else                                        w_after = w_word_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    dma_en       = 1'b0;
    dma_we       = 2'b00;
    dma_addr     = '0;
    dma_out      = '0;
    dev_out      = '0;
    dma_ack      = '0;
    end_flag     = r_zend;
    err_flag     = '0;
    dma_priority = (r_state != IDLE) && HIPRIO_MASK[r_ch];
    case (r_state)
      IDLE:   if (|w_busy) w_next = ARB;
      ARB:    w_next = w_word_nx;
      MEM_RD: begin
        dma_en   = 1'b1;
        dma_addr = r_addr;
        if (dma_ready) w_next = dma_resp ? ERROR : DEV_WR;
      end
      DEV_WR: begin
        dma_ack = w_ch_oh;
        dev_out = r_stage;
        if (dev_ack[r_ch]) w_next = w_after;
      end
      DEV_RD: if (dev_ack[r_ch]) begin
        dma_ack = w_ch_oh;
        w_next  = MEM_WR;
      end
      MEM_WR: begin
        dma_en   = 1'b1;
        dma_we   = WE_WORD;
        dma_addr = r_addr;
        dma_out  = r_stage;
        if (dma_ready) w_next = dma_resp ? ERROR : w_after;
      end
      YIELD:  w_next = IDLE;
      DONE: begin
        end_flag = r_zend | w_ch_oh;
        w_next   = IDLE;
      end
      ERROR: begin
        err_flag = w_ch_oh;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Capture only touches idle channels; the FSM only writes the owned (busy) one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctx   <= '0;
      r_ch    <= '0;
      r_addr  <= '0;
      r_rem   <= '0;
      r_burst <= '0;
      r_stage <= '0;
      r_zend  <= '0;
    end else begin
      r_zend <= '0;
      for (int c = 0; c < NCH; c++) begin
        if (rqst[c] && !r_ctx[c].busy) begin
          r_ctx[c].cur_addr  <= w_sa[c];
          r_ctx[c].remaining <= w_nw[c];
          r_ctx[c].dir       <= rd_wr[c];
          r_ctx[c].busy      <= (w_nw[c] != '0);
          r_zend[c]          <= (w_nw[c] == '0);
        end
      end
      case (r_state)
        IDLE: if (|w_grant) r_ch <= w_gidx;
        ARB: begin
          r_addr  <= r_ctx[r_ch].cur_addr;
          r_rem   <= r_ctx[r_ch].remaining;
          r_burst <= '0;
        end
        MEM_RD: if (dma_ready && !dma_resp) r_stage <= dma_in;
        DEV_RD: if (dev_ack[r_ch]) r_stage <= w_din[r_ch];
        YIELD: begin
          r_ctx[r_ch].cur_addr  <= r_addr;
          r_ctx[r_ch].remaining <= r_rem;
          r_burst               <= '0;
        end
        DONE, ERROR: r_ctx[r_ch].busy <= 1'b0;
        default: ;
      endcase
      if (w_step) begin
        r_addr  <= r_addr + ADDR_W'(1);
        r_rem   <= r_rem - ADDR_W'(1);
        r_burst <= r_burst + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_dma_mc_controller.sv
// Directed bench: per-cycle vector tables for single transfers and errors,
// hand sequences for round-robin bursts, address wrap and mid-transfer reset.
module tb_dma_mc_controller;
  localparam int NCH = 4, AW = 16, DW = 16, BL = 8;
  localparam logic [NCH-1:0] HP = 4'b1000;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0] rqst = '0, rd_wr = '0, dev_ack = '0;
  logic [NCH*(AW+1)-1:0] start_addr = '0;
  logic [NCH*AW-1:0] num_words = '0;
  logic [NCH*DW-1:0] dev_in = '0;
  logic [DW-1:0] dma_in = '0;
  logic dma_ready = 1'b0, dma_resp = 1'b0;
  logic [DW-1:0] dev_out, dma_out;
  logic [AW-1:0] dma_addr;
  logic [NCH-1:0] dma_ack, end_flag, err_flag, busy;
  logic dma_en, dma_priority;
  logic [1:0] dma_we;

  dma_mc_controller #(.ADDR_W(AW), .DATA_W(DW), .NCH(NCH), .BURST_LEN(BL), .HIPRIO_MASK(HP)) dut (
    .clk(clk), .reset(reset), .rqst(rqst), .rd_wr(rd_wr), .start_addr(start_addr),
    .num_words(num_words), .dev_ack(dev_ack), .dev_in(dev_in), .dev_out(dev_out),
    .dma_ack(dma_ack), .end_flag(end_flag), .err_flag(err_flag), .busy(busy),
    .dma_in(dma_in), .dma_ready(dma_ready), .dma_resp(dma_resp), .dma_addr(dma_addr),
    .dma_out(dma_out), .dma_en(dma_en), .dma_we(dma_we), .dma_priority(dma_priority));

  typedef struct {
    logic [3:0] rq, rw, dack; logic [15:0] din, dmain; logic rdy, resp;
    logic [3:0] busy; logic en; logic [1:0] we; logic [15:0] addr, dout, devout;
    logic [3:0] ack, endf, err; logic pri;
  } vec_t;
  vec_t tv[$];

  int total = 0, bad = 0;

  function automatic vec_t v(input logic [3:0] rq, rw, dack, input logic [15:0] din, dmain,
      input logic rdy, resp, input logic [3:0] eb, input logic een, input logic [1:0] ewe,
      input logic [15:0] ea, edo, edv, input logic [3:0] eack, eend, eerr, input logic epri);
    vec_t r;
    r.rq = rq; r.rw = rw; r.dack = dack; r.din = din; r.dmain = dmain; r.rdy = rdy; r.resp = resp;
    r.busy = eb; r.en = een; r.we = ewe; r.addr = ea; r.dout = edo; r.devout = edv;
    r.ack = eack; r.endf = eend; r.err = eerr; r.pri = epri;
    return r;
  endfunction

  function automatic logic [67:0] outs();
    return {busy, dma_en, dma_we, dma_addr, dma_out, dev_out, dma_ack, end_flag, err_flag, dma_priority};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [16:0] sa, input logic [15:0] nw);
    start_addr[c*(AW+1) +: AW+1] = sa;
    num_words[c*AW +: AW] = nw;
  endtask

  task automatic run_table(input string nm);
    foreach (tv[i]) begin
      @(negedge clk);
      rqst = tv[i].rq; rd_wr = tv[i].rw; dev_ack = tv[i].dack; dev_in = {NCH{tv[i].din}};
      dma_in = tv[i].dmain; dma_ready = tv[i].rdy; dma_resp = tv[i].resp;
      #2;
      chk(nm, i, outs(), {tv[i].busy, tv[i].en, tv[i].we, tv[i].addr, tv[i].dout, tv[i].devout,
                          tv[i].ack, tv[i].endf, tv[i].err, tv[i].pri});
    end
    tv.delete();
  endtask

  initial begin
    logic [17:0] lg[$], ex[$];
    int e0, e2, e1, n1, seen;
    logic [15:0] got_a, got_d;

    #2 chk("reset", 0, outs(), '0);
    @(negedge clk) reset = 1'b0;
    #2 chk("post_reset", 0, outs(), '0);

    // ch0 read, 3 words at byte 0x0200
    set_ch(0, 17'h0200, 16'd3);
    tv.push_back(v(4'h1,4'h1,4'h0,16'h0,16'h0,0,0, 4'h0,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h1,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h1,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h1,1,2'b00,16'h0100,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h00A1,1,0, 4'h1,1,2'b00,16'h0100,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h1,0,2'b00,16'h0,16'h0,16'h00A1,4'h1,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h1,16'h0,16'h0,0,0, 4'h1,0,2'b00,16'h0,16'h0,16'h00A1,4'h1,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h00A2,1,0, 4'h1,1,2'b00,16'h0101,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h1,16'h0,16'h0,0,0, 4'h1,0,2'b00,16'h0,16'h0,16'h00A2,4'h1,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h00A3,1,0, 4'h1,1,2'b00,16'h0102,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h1,16'h0,16'h0,0,0, 4'h1,0,2'b00,16'h0,16'h0,16'h00A3,4'h1,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h1,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h1,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h0,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    run_table("rd_ch0");

    // ch1 write, 2 words at byte 0x0400, first memory write stalls 3 cycles
    set_ch(1, 17'h0400, 16'd2);
    tv.push_back(v(4'h2,4'h0,4'h0,16'h0,16'h0,0,0, 4'h0,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h2,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h2,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h2,16'h1111,16'h0,0,0, 4'h2,0,2'b00,16'h0,16'h0,16'h0,4'h2,4'h0,4'h0,0));
    for (int k = 0; k < 3; k++)
      tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h2,1,2'b11,16'h0200,16'h1111,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,1,0, 4'h2,1,2'b11,16'h0200,16'h1111,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h2222,16'h0,0,0, 4'h2,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h2,16'h2222,16'h0,0,0, 4'h2,0,2'b00,16'h0,16'h0,16'h0,4'h2,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h2222,16'h0,1,0, 4'h2,1,2'b11,16'h0201,16'h2222,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h2,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h2,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h0,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    run_table("wr_ch1");

    // ch3 zero-length: end pulse only, no memory access
    set_ch(3, 17'h0800, 16'd0);
    tv.push_back(v(4'h8,4'h0,4'h0,16'h0,16'h0,0,0, 4'h0,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h0,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h8,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h0,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    run_table("zero_ch3");

    // ch2 read errors on word 2; queued ch3 (high priority) write then runs
    set_ch(2, 17'h0600, 16'd4);
    set_ch(3, 17'h0800, 16'd1);
    tv.push_back(v(4'hC,4'h4,4'h0,16'h0,16'h0,0,0, 4'h0,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'hC,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'hC,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h00B1,1,0, 4'hC,1,2'b00,16'h0300,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h4,16'h0,16'h0,0,0, 4'hC,0,2'b00,16'h0,16'h0,16'h00B1,4'h4,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h00B2,1,1, 4'hC,1,2'b00,16'h0301,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h4,16'h0,16'h0,0,0, 4'hC,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h4,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h8,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h8,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,1));
    tv.push_back(v(4'h0,4'h0,4'h8,16'h3333,16'h0,0,0, 4'h8,0,2'b00,16'h0,16'h0,16'h0,4'h8,4'h0,4'h0,1));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h3333,16'h0,1,0, 4'h8,1,2'b11,16'h0400,16'h3333,16'h0,4'h0,4'h0,4'h0,1));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h8,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h8,4'h0,1));
    tv.push_back(v(4'h0,4'h0,4'h0,16'h0,16'h0,0,0, 4'h0,0,2'b00,16'h0,16'h0,16'h0,4'h0,4'h0,4'h0,0));
    run_table("err_ch2");

    // Round robin: ch0 read and ch2 write, 20 words each, bursts of 8
    set_ch(0, 17'h1000, 16'd20);
    set_ch(2, 17'h2000, 16'd20);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < ((r < 2) ? 8 : 4); k++) ex.push_back({2'b00, 16'(16'h0800 + r*8 + k)});
      for (int k = 0; k < ((r < 2) ? 8 : 4); k++) ex.push_back({2'b11, 16'(16'h1000 + r*8 + k)});
    end
    e0 = 0; e2 = 0;
    dev_ack = 4'b0101; dma_ready = 1'b1; dma_resp = 1'b0; rd_wr = 4'b0001;
    dev_in = {NCH{16'h5555}}; dma_in = 16'h7777;
    for (int cyc = 0; cyc < 600 && !(e0 > 0 && e2 > 0); cyc++) begin
      @(negedge clk);
      rqst = (cyc == 0) ? 4'b0101 : 4'b0000;
      #2;
      if (dma_en) lg.push_back({dma_we, dma_addr});
      e0 += int'(end_flag[0]);
      e2 += int'(end_flag[2]);
    end
    chk("rr_count", 0, 68'(lg.size()), 68'(40));
    foreach (ex[i]) chk("rr_access", i, (i < lg.size()) ? 68'(lg[i]) : '1, 68'(ex[i]));
    @(negedge clk); #2;
    chk("rr_ends", 0, {60'(e0), 8'(e2)}, {60'(1), 8'(1)});
    chk("rr_idle", 0, 68'(busy), 68'(0));

    // Address wrap: ch1 read from word 0xFFFF, 2 words
    lg.delete();
    set_ch(1, 17'h1FFFE, 16'd2);
    dev_ack = 4'b0010; rd_wr = 4'b0010; n1 = 0; e0 = 0;
    for (int cyc = 0; cyc < 40 && n1 == 0; cyc++) begin
      @(negedge clk);
      rqst = (cyc == 0) ? 4'b0010 : 4'b0000;
      #2;
      if (dma_en) lg.push_back({2'b00, dma_addr});
      n1 += int'(err_flag[1]);
      e0 += int'(end_flag[1]);
    end
    chk("wrap_err", 0, {60'(n1), 8'(e0)}, {60'(1), 8'(0)});
    chk("wrap_access", 0, {60'(lg.size()), (lg.size() > 0) ? 8'(lg[0][15:8]) : 8'h00}, {60'(1), 8'hFF});
    @(negedge clk); #2;
    chk("wrap_busy", 0, 68'(busy), 68'(0));

    // Reset while ch1 write is stalled in its memory write
    set_ch(1, 17'h0400, 16'd2);
    dev_ack = 4'b0010; rd_wr = 4'b0000; dma_ready = 1'b0; dev_in = {NCH{16'h4444}};
    seen = 0;
    for (int cyc = 0; cyc < 20 && seen == 0; cyc++) begin
      @(negedge clk);
      rqst = (cyc == 0) ? 4'b0010 : 4'b0000;
      #2;
      if (dma_en && dma_we == 2'b11) seen = 1;
    end
    chk("rst_reach_memwr", 0, 68'(seen), 68'(1));
    #1 reset = 1'b1;
    #1 chk("rst_outputs", 0, outs(), '0);
    rqst = '0; dev_ack = '0;
    @(negedge clk) reset = 1'b0;
    n1 = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk); #2;
      n1 += int'(|{end_flag, err_flag, busy, dma_en});
    end
    chk("rst_silent", 0, 68'(n1), 68'(0));

    // Fresh request after reset: ch0 read, 1 word at byte 0x0010
    set_ch(0, 17'h0010, 16'd1);
    rd_wr = 4'b0001; dev_ack = 4'b0001; dma_ready = 1'b1; dma_in = 16'hBEEF;
    got_a = '0; got_d = '0; seen = 0;
    for (int cyc = 0; cyc < 20 && seen == 0; cyc++) begin
      @(negedge clk);
      rqst = (cyc == 0) ? 4'b0001 : 4'b0000;
      #2;
      if (dma_en) got_a = dma_addr;
      if (dma_ack[0]) got_d = dev_out;
      if (end_flag[0]) seen = 1;
    end
    chk("fresh", 0, {35'(seen), got_a, got_d}, {35'(1), 16'h0008, 16'hBEEF});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dma_mc_controller.md
Name: dma_mc_controller

Overview:
- Multi-channel DMA engine between up to NCH peripheral devices and the openMSP430 DMA memory port.
- Each channel independently requests a memory-read (mem->dev) or memory-write (dev->mem) block transfer.
- A round-robin arbiter time-slices the single memory port in bursts of BURST_LEN words, saving and restoring per-channel address and word-count context.
- Word-by-word operation with a one-word staging register; no bulk FIFO.

Parameters:
- ADDR_W, 16, physical word-address width.
- DATA_W, 16, data word width.
- NCH, 4, number of channels (2..8).
- BURST_LEN, 8, words moved per grant before re-arbitration (power of two, 1..64).
- HIPRIO_MASK, 0, NCH-bit mask; a set bit drives dma_priority=1 while that channel owns the port.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rqst  in  NCH  per-channel transfer request; sampled only while the channel is inactive
- rd_wr  in  NCH  1 = memory read to device, 0 = device write to memory
- start_addr  in  NCH*(ADDR_W+1)  logical byte address; physical word address = start_addr>>1
- num_words  in  NCH*ADDR_W  transfer length in words
- dev_ack  in  NCH  device handshake: accepts dev_out (read) or presents dev_in valid (write)
- dev_in  in  NCH*DATA_W  device write data
- dev_out  out  DATA_W  shared read data to the owning channel
- dma_ack  out  NCH  read: dev_out valid; write: dev_in consumed this cycle
- end_flag  out  NCH  one-cycle pulse, transfer complete
- err_flag  out  NCH  one-cycle pulse, transfer aborted
- busy  out  NCH  channel holds an active transfer
- dma_in  in  DATA_W  memory read data
- dma_ready  in  1  memory access completes this cycle
- dma_resp  in  1  memory error, valid with dma_ready
- dma_addr  out  ADDR_W  memory word address
- dma_out  out  DATA_W  memory write data
- dma_en  out  1  memory access request
- dma_we  out  2  byte write enables (11 on writes, 00 on reads)
- dma_priority  out  1  priority request

Behaviour:
- Reset: every output is 0, including dma_addr and dev_out (no tri-state). All contexts are cleared, the arbiter pointer is 0, and the FSM is in IDLE. Reset mid-transfer aborts silently, with no end_flag or err_flag.
- Context capture: for each channel with rqst=1 and busy=0, on the next edge latch cur_addr=start_addr>>1 and remaining=num_words, then set busy. num_words=0 pulses end_flag one cycle later with no memory access, and busy stays 0.
- Arbiter:
  - Round-robin among busy channels, starting at the channel after the last grant.
  - Evaluated only in IDLE.
  - Grant takes 1 cycle (ARB).
- FSM states: IDLE, ARB, MEM_RD, DEV_WR, DEV_RD, MEM_WR, YIELD, DONE, ERROR.
- Read path (rd_wr=1):
  - MEM_RD: dma_en=1, dma_addr=cur_addr. On dma_ready, capture dma_in into the stage register and go to DEV_WR.
  - DEV_WR: dma_ack[ch]=1 and dev_out=stage, held until dev_ack[ch]. On the handshake, decrement remaining, increment cur_addr and the burst counter.
- Write path (rd_wr=0):
  - DEV_RD: wait for dev_ack[ch]. Capture dev_in into stage and pulse dma_ack[ch] in the same cycle.
  - MEM_WR: dma_en=1, dma_we=11, dma_out=stage, held until dma_ready. Then update counters as on the read path.
- After each word:
  - remaining==0 -> DONE.
  - Otherwise, burst count==BURST_LEN -> YIELD.
  - Otherwise, continue with the next word.
- YIELD: write back context, clear the burst counter, return to IDLE. Round-robin gives other busy channels the port.
- DONE: pulse end_flag[ch], clear busy[ch], return to IDLE.
- Errors:
  - dma_resp=1 with dma_ready -> ERROR. Pulse err_flag[ch], clear busy, discard the current word, return to IDLE.
  - Address wrap: incrementing cur_addr from all-ones with remaining>0 also goes to ERROR. No access is made at the wrapped address.
- dma_en is never deasserted mid-access before dma_ready. dma_addr and dma_out are stable while dma_en=1.
- Simultaneous events:
  - rqst on a busy channel is ignored.
  - A new rqst arriving during another channel's burst is captured but waits for arbitration.
  - end_flag and new-request capture on the same channel in the same cycle: capture wins on the following cycle.
- Latency: a single-channel word costs 1 memory wait plus 1 device handshake cycle minimum. Grant overhead is 2 cycles (IDLE, ARB).

Decomposition:
- Shared package dma_pkg:
  - FSM state encoding.
  - Channel context struct {cur_addr, remaining, busy, dir}.
  - Constants DIR_RD/DIR_WR and WE_WORD=2'b11.
- Sub-module dma_rr_arbiter: parametrised NCH round-robin, with inputs req and advance, output one-hot grant, registered pointer.

Test Plan:
- Ch0 read, start_addr=0x0200, num_words=3, memory returns 0xA1,0xA2,0xA3 -> dma_addr 0x0100,0x0101,0x0102; dev_out 0xA1..0xA3 with dma_ack; end_flag[0] pulses once.
- Ch1 write, num_words=2, dev_in 0x1111,0x2222, dma_ready delayed 3 cycles -> dma_en held, dma_we=11, writes to start_addr>>1 and +1; end_flag[1].
- Ch0 and ch2 both request 20 words, BURST_LEN=8 -> grants ch0(8), ch2(8), ch0(8), ch2(8), ch0(4), ch2(4); address continuity per channel across yields.
- num_words=0 on ch3 -> end_flag[3] one cycle after capture; dma_en never asserted.
- dma_resp=1 on the 2nd word of a 4-word read -> err_flag pulse, busy cleared, no dev handshake for that word, next busy channel granted.
- Reset asserted in MEM_WR -> all outputs 0 immediately; no end or error pulse; a fresh request afterwards completes normally.
